// File: rtl/dcache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : dcache_pkg                                                   |
// | Description : Shared types and constants for the dcache Wishbone master:   |
// |               FSM state encoding, error/invalid data pattern, byte-select. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package dcache_pkg;

  // Two-state bus master FSM; explicit 1-bit encoding.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUS  = 1'b1
  } dcwb_state_e;

  // Returned as read data whenever a transaction completes with an error.
  localparam logic [31:0] INVALID_ADDR = 32'hDEAD_BEEF;

  // Only full-word accesses are issued.
  localparam logic [3:0]  WB_SEL_FULL  = 4'hF;

  // Width of the optional watchdog counter.
  localparam int          TMO_CNT_W    = 16;

endpackage : dcache_pkg
`default_nettype wire

// File: rtl/dcache_wb_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dcache_wb_master                                             |
// | Description : Wishbone B4 classic single-beat master behind the dcache     |
// |               MSHR queue. Accepts one load/writeback request pulse, runs   |
// |               one bus cycle, returns read data with a one-cycle valid.     |
// | Ports       : clk, rst (async, active-high)                                |
// |               req/we/addr/wdata      - request from MSHR head entry        |
// |               rdata/valid/err        - registered completion              |
// |               busy                   - transaction in flight              |
// |               drop_err               - sticky: req arrived while busy     |
// |               wb_*_o / wb_*_i        - Wishbone master interface          |
// | Options     : DCWB_TIMEOUT_EN - enables the BUS-state watchdog, which      |
// |               ends a stalled cycle after TIMEOUT_CYCLES with err=1.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dcache_wb_master
  import dcache_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              valid,
  output logic              err,
  output logic              busy,
  output logic              drop_err,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic [3:0]        wb_sel_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  // Byte-offset bits are discarded at capture: word-aligned accesses only.
  localparam logic [ADDR_W-1:0] c_addr_mask = {{(ADDR_W-2){1'b1}}, 2'b00};

  if (DATA_W != 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << TMO_CNT_W)) begin : g_param_check
    $error("dcache_wb_master: unsupported DATA_W or TIMEOUT_CYCLES");
  end

  dcwb_state_e       r_state;
  dcwb_state_e       w_state_nxt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_accept;
  logic              w_done;
  logic              w_done_err;
  logic              w_drop;
  logic              w_timeout;

  // --------------------------------------------------------------------------
  // Optional watchdog. Counts BUS cycles that saw neither ack nor err; the
  // count restarts on every accepted request.
  // --------------------------------------------------------------------------
`ifdef DCWB_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (w_accept) begin
      r_tmo_cnt <= '0;
    end else if (r_state == BUS && !wb_ack_i && !wb_err_i) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == BUS) &&
                     (r_tmo_cnt == TMO_CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state / completion decode. Slave error beats ack; ack beats the
  // watchdog, so a late ack on the final watchdog cycle still succeeds.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_done_err  = 1'b0;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_accept    = 1'b1;
          w_state_nxt = BUS;
        end
      end
      BUS: begin
        if (wb_err_i) begin
          w_done      = 1'b1;
          w_done_err  = 1'b1;
          w_state_nxt = IDLE;
        end else if (wb_ack_i) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_timeout) begin
          w_done      = 1'b1;
          w_done_err  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A request during BUS (including the completing cycle) is not accepted.
  assign w_drop = req && (r_state == BUS);

  // --------------------------------------------------------------------------
  // Holding registers and registered completion outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      rdata    <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      valid <= w_done;
      err   <= w_done_err;
      if (w_accept) begin
        r_we    <= we;
        r_addr  <= addr & c_addr_mask;
        r_wdata <= wdata;
      end
      // Writes leave rdata untouched unless they fail.
      if (w_done) begin
        if (w_done_err) begin
          rdata <= DATA_W'(INVALID_ADDR);
        end else if (!r_we) begin
          rdata <= wb_dat_i;
        end
      end
      if (w_drop) begin
        drop_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Bus outputs: cyc/stb follow the state register, everything else comes
  // from the holding registers so it is stable for the whole cycle.
  // --------------------------------------------------------------------------
  assign busy     = (r_state == BUS);
  assign wb_cyc_o = busy;
  assign wb_stb_o = busy;
  assign wb_we_o  = r_we;
  assign wb_adr_o = r_addr;
  assign wb_dat_o = r_wdata;
  assign wb_sel_o = WB_SEL_FULL;

endmodule : dcache_wb_master
`default_nettype wire

// File: tb/tb_dcache_wb_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dcache_wb_master                                          |
// | Description : Self-checking bench for dcache_wb_master. Directed scenarios |
// |               plus randomized transactions against a transaction-level     |
// |               reference model (latency = ack delay + 1, word address,     |
// |               rdata update rules). DCWB_TIMEOUT_EN selects the watchdog    |
// |               scenario with TIMEOUT_CYCLES = 8.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dcache_wb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        valid, err, busy, drop_err;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;
  int n_valid      = 0;
  int n_double     = 0;
  int exp_valid    = 0;
  logic prev_valid = 1'b0;
  logic [31:0] model_rdata = '0;

  dcache_wb_master #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .valid    (valid),
    .err      (err),
    .busy     (busy),
    .drop_err (drop_err),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i)
  );

  always #5 clk = ~clk;

  // Valid-pulse monitor: counts pulses and back-to-back valid cycles.
  always @(posedge clk) begin
    if (valid === 1'b1 && prev_valid === 1'b1) n_double++;
    if (valid === 1'b1) n_valid++;
    prev_valid <= valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "bench watchdog expired");
  end

  // Issues one request at the current negedge and plays a slave that raises
  // ack (and err when t_err) in the t_delay-th cycle of cyc (0 = never).
  // Returns at the negedge where valid is seen (or after a 100-cycle budget).
  task automatic run_txn(input logic t_we, input logic [31:0] t_addr,
                         input logic [31:0] t_wdata, input logic [31:0] t_rdat,
                         input int t_delay, input logic t_err,
                         output int o_cyc, output int o_lat, output logic o_stable,
                         output logic [31:0] o_rdata, output logic o_err,
                         output logic [31:0] o_adr, output logic [31:0] o_dat,
                         output logic o_we);
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
    @(negedge clk);
    req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom;
    o_cyc = 0; o_lat = 1; o_stable = 1'b1;
    o_adr = wb_adr_o; o_dat = wb_dat_o; o_we = wb_we_o;
    while (valid !== 1'b1 && o_lat < 100) begin
      if (wb_cyc_o === 1'b1) begin
        o_cyc++;
        if (wb_adr_o !== o_adr || wb_dat_o !== o_dat || wb_we_o !== o_we || wb_stb_o !== 1'b1)
          o_stable = 1'b0;
        if (o_cyc == t_delay) begin
          wb_ack_i = 1'b1; wb_err_i = t_err; wb_dat_i = t_rdat;
        end
      end
      @(negedge clk);
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
      o_lat++;
    end
    o_rdata = rdata; o_err = err;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    tests_run++;
    if ({valid, err, busy, drop_err, wb_cyc_o, wb_stb_o, wb_we_o} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {valid, err, busy, drop_err, wb_cyc_o, wb_stb_o, wb_we_o});
    end
    tests_run++;
    if (rdata !== 32'h0 || wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data: rdata %h adr %h dat %h expected all 0", rdata, wb_adr_o, wb_dat_o);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_idle: busy %b expected 0", busy);
    end
  endtask

  task automatic test_read();
    int c, l; logic st, e, w; logic [31:0] rd, a, d;
    run_txn(1'b0, 32'h0000_0010, $urandom, 32'h1234_5678, 3, 1'b0, c, l, st, rd, e, a, d, w);
    exp_valid++; model_rdata = 32'h1234_5678;
    tests_run++;
    if (c !== 3) begin tests_failed++; $display("FAIL read_cyc_len: got %0d expected 3", c); end
    tests_run++;
    if (l !== 4) begin tests_failed++; $display("FAIL read_latency: got %0d expected 4", l); end
    tests_run++;
    if (rd !== 32'h1234_5678 || e !== 1'b0) begin
      tests_failed++; $display("FAIL read_data: rdata %h err %b expected 12345678 0", rd, e);
    end
    tests_run++;
    if (a !== 32'h10 || w !== 1'b0 || st !== 1'b1) begin
      tests_failed++; $display("FAIL read_bus: adr %h we %b stable %b expected 10 0 1", a, w, st);
    end
    @(negedge clk);
    tests_run++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL read_valid_pulse: valid %b busy %b expected 0 0", valid, busy);
    end
  endtask

  task automatic test_write();
    int c, l; logic st, e, w; logic [31:0] rd, a, d;
    run_txn(1'b1, 32'h0000_0104, 32'hCAFE_F00D, $urandom, 1, 1'b0, c, l, st, rd, e, a, d, w);
    exp_valid++;
    tests_run++;
    if (w !== 1'b1 || d !== 32'hCAFE_F00D || a !== 32'h104 || st !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_bus: we %b dat %h adr %h stable %b expected 1 cafef00d 104 1", w, d, a, st);
    end
    tests_run++;
    if (l !== 2 || c !== 1) begin
      tests_failed++; $display("FAIL write_latency: lat %0d cyc %0d expected 2 1", l, c);
    end
    tests_run++;
    if (rd !== model_rdata || e !== 1'b0) begin
      tests_failed++; $display("FAIL write_rdata_hold: rdata %h err %b expected %h 0", rd, e, model_rdata);
    end
    tests_run++;
    if (wb_sel_o !== 4'hF) begin
      tests_failed++; $display("FAIL write_sel: got %h expected f", wb_sel_o);
    end
  endtask

  task automatic test_back_to_back();
    int c, l, n0; logic st, e, w; logic [31:0] rd, a, d, r1, r2;
    r1 = $urandom; r2 = $urandom;
    @(negedge clk);
    n0 = n_valid;
    run_txn(1'b0, 32'h0000_0100, $urandom, r1, 2, 1'b0, c, l, st, rd, e, a, d, w);
    exp_valid++;
    tests_run++;
    if (rd !== r1) begin tests_failed++; $display("FAIL b2b_first_data: got %h expected %h", rd, r1); end
    // Second request issued in the cycle where the first valid is high.
    run_txn(1'b0, 32'h0000_0020, $urandom, r2, 1, 1'b0, c, l, st, rd, e, a, d, w);
    exp_valid++; model_rdata = r2;
    tests_run++;
    if (l !== 2 || a !== 32'h20 || rd !== r2) begin
      tests_failed++;
      $display("FAIL b2b_second: lat %0d adr %h rdata %h expected 2 20 %h", l, a, rd, r2);
    end
    @(negedge clk);
    tests_run++;
    if (n_valid - n0 !== 2 || drop_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_count: valids %0d drop_err %b expected 2 0", n_valid - n0, drop_err);
    end
  endtask

  task automatic test_slave_err();
    int c, l; logic st, e, w; logic [31:0] rd, a, d;
    @(negedge clk);
    run_txn(1'b0, 32'h0000_0200, $urandom, 32'h0BAD_0BAD, 2, 1'b1, c, l, st, rd, e, a, d, w);
    exp_valid++; model_rdata = 32'hDEAD_BEEF;
    tests_run++;
    if (l !== 3 || e !== 1'b1 || rd !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL slave_err: lat %0d err %b rdata %h expected 3 1 deadbeef", l, e, rd);
    end
  endtask

  task automatic test_random();
    int c, l, dly, gap; logic st, e, w, t_we, t_err; logic [31:0] rd, a, d, t_addr, t_wd, t_rd;
    for (int i = 0; i < 24; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) @(negedge clk);
      t_we = 1'($urandom); t_addr = $urandom; t_wd = $urandom; t_rd = $urandom;
      dly = $urandom_range(1, 5); t_err = ($urandom_range(0, 4) == 0);
      run_txn(t_we, t_addr, t_wd, t_rd, dly, t_err, c, l, st, rd, e, a, d, w);
      exp_valid++;
      if (t_err) model_rdata = 32'hDEAD_BEEF;
      else if (!t_we) model_rdata = t_rd;
      tests_run++;
      if (l !== dly + 1 || c !== dly || st !== 1'b1) begin
        tests_failed++;
        $display("FAIL rand_timing[%0d]: lat %0d cyc %0d stable %b expected %0d %0d 1", i, l, c, st, dly + 1, dly);
      end
      tests_run++;
      if (a !== {t_addr[31:2], 2'b00} || w !== t_we || d !== t_wd) begin
        tests_failed++;
        $display("FAIL rand_bus[%0d]: adr %h we %b dat %h expected %h %b %h", i, a, w, d,
                 {t_addr[31:2], 2'b00}, t_we, t_wd);
      end
      tests_run++;
      if (rd !== model_rdata || e !== t_err) begin
        tests_failed++;
        $display("FAIL rand_result[%0d]: rdata %h err %b expected %h %b", i, rd, e, model_rdata, t_err);
      end
    end
  endtask

  task automatic test_spurious();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      wb_ack_i = 1'b1; wb_err_i = 1'(i); wb_dat_i = $urandom;
      @(negedge clk);
      tests_run++;
      if (valid !== 1'b0 || busy !== 1'b0 || rdata !== model_rdata) begin
        tests_failed++;
        $display("FAIL spurious_ack[%0d]: valid %b busy %b rdata %h expected 0 0 %h", i, valid, busy, rdata, model_rdata);
      end
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
  endtask

  task automatic test_timeout();
    int c, l; logic st, e, w; logic [31:0] rd, a, d;
    @(negedge clk);
`ifdef DCWB_TIMEOUT_EN
    run_txn(1'b0, 32'h0000_0300, $urandom, $urandom, 0, 1'b0, c, l, st, rd, e, a, d, w);
    exp_valid++; model_rdata = 32'hDEAD_BEEF;
    tests_run++;
    if (c !== 8 || l !== 9 || e !== 1'b1 || rd !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL timeout: cyc %0d lat %0d err %b rdata %h expected 8 9 1 deadbeef", c, l, e, rd);
    end
    @(negedge clk);
    run_txn(1'b0, 32'h0000_0304, $urandom, 32'h600D_600D, 8, 1'b0, c, l, st, rd, e, a, d, w);
    exp_valid++; model_rdata = 32'h600D_600D;
    tests_run++;
    if (c !== 8 || e !== 1'b0 || rd !== 32'h600D_600D) begin
      tests_failed++;
      $display("FAIL timeout_ack_wins: cyc %0d err %b rdata %h expected 8 0 600d600d", c, e, rd);
    end
`else
    run_txn(1'b0, 32'h0000_0300, $urandom, 32'h5107_5107, 20, 1'b0, c, l, st, rd, e, a, d, w);
    exp_valid++; model_rdata = 32'h5107_5107;
    tests_run++;
    if (c !== 20 || e !== 1'b0 || rd !== 32'h5107_5107) begin
      tests_failed++;
      $display("FAIL no_timeout_wait: cyc %0d err %b rdata %h expected 20 0 51075107", c, e, rd);
    end
`endif
  endtask

  task automatic test_busy_req();
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0000_0040; wdata = $urandom;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h0000_0080; wdata = $urandom;
    @(negedge clk);
    req = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || wb_adr_o !== 32'h40 || wb_we_o !== 1'b0 || drop_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_req: busy %b adr %h we %b drop_err %b expected 1 40 0 1", busy, wb_adr_o, wb_we_o, drop_err);
    end
    wb_ack_i = 1'b1; wb_dat_i = 32'h5555_AAAA;
    @(negedge clk);
    wb_ack_i = 1'b0;
    exp_valid++; model_rdata = 32'h5555_AAAA;
    tests_run++;
    if (valid !== 1'b1 || err !== 1'b0 || rdata !== 32'h5555_AAAA) begin
      tests_failed++;
      $display("FAIL busy_req_done: valid %b err %b rdata %h expected 1 0 5555aaaa", valid, err, rdata);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (drop_err !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_err_sticky: drop_err %b busy %b expected 1 0", drop_err, busy);
    end
  endtask

  task automatic test_reset_mid();
    int late_valid;
    // Settle the global valid bookkeeping before the transaction is lost.
    @(negedge clk); @(negedge clk);
    tests_run++;
    if (n_valid !== exp_valid || n_double !== 0) begin
      tests_failed++;
      $display("FAIL valid_count: got %0d doubles %0d expected %0d 0", n_valid, n_double, exp_valid);
    end
    req = 1'b1; we = 1'b0; addr = 32'h0000_0030;
    @(negedge clk);
    req = 1'b0;
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: cyc %b stb %b busy %b expected 0 0 0", wb_cyc_o, wb_stb_o, busy);
    end
    @(negedge clk);
    rst = 1'b0; wb_ack_i = 1'b1; wb_dat_i = $urandom;
    late_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wb_ack_i = 1'b0;
      if (valid !== 1'b0 || wb_cyc_o !== 1'b0) late_valid++;
    end
    tests_run++;
    if (late_valid !== 0 || drop_err !== 1'b0 || rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_lost_txn: bad cycles %0d drop_err %b rdata %h expected 0 0 0", late_valid, drop_err, rdata);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_slave_err();
    test_random();
    test_spurious();
    test_timeout();
    test_busy_req();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_dcache_wb_master
`default_nettype wire
